cov_engine: RTL and testbench
=============================

# cov_engine

Fixed-point covariance responder for the program-3 Start/Ack protocol. The host side holds `Start` high while it loads N and the X/Y operand arrays into data memory. It then drops `Start` and waits for `Ack`. `cov_engine` is the execution end of that handshake: it reads the operands from data memory, computes the 8.8 covariance, writes the 16-bit result back, and raises `Ack`. It sits beside the data memory and can stand in for the CPU when checking the program-3 test vectors.

## Interface
- `NMAX`, 255: largest legal N; also the memory depth limit for `2*N+2`.
- `Clk`  in  1: system clock; all state changes on the rising edge.
- `Reset`  in  1: asynchronous, active-high; forces IDLE.
- `Start`  in  1: host request. High means hold/abort. A high→low transition launches a run.
- `Ack`  out  1: run complete; high from the end of the run until `Start` rises or `Reset` asserts.
- `MemAddr`  out  8: data-memory address.
- `MemRdData`  in  8: combinational read data for `MemAddr`, same cycle.
- `MemWrEn`  out  1: write strobe; memory captures `MemWrData` at `MemAddr` on the rising edge.
- `MemWrData`  out  8: write data.

## Operation
Memory map:
- `Core[0]` = N.
- `Core[1..N]` = X.
- `Core[N+1..2N]` = Y.
- Result high byte at `Core[2N+1]`, low byte at `Core[2N+2]`.

Launch: `Start` is registered. A run begins on the cycle after the registered `Start` goes 1→0 while in IDLE or DONE.

States and actions:
- IDLE
- LOADN: 1 cycle; latch N from address 0.
- SUMX: N cycles; `acc += {X_i, 8'h00}`.
- DIVX: 17 cycles; `xbar = acc / N`.
- SUMY: N cycles; `acc += {Y_i, 8'h00}`.
- DIVY: 17 cycles; `ybar = acc / N`.
- COV: 2N cycles; read X_i, then Y_i. `acc += ((X_i<<8) - xbar) * ((Y_i<<8) - ybar)` bits [23:8].
- DIVC: 17 cycles.
- WRHI: 1 cycle.
- WRLO: 1 cycle.
- DONE: `Ack` high.

The accumulator is cleared on entry to each SUM/COV phase.

Arithmetic:
- Accumulator is 16 bits signed and wraps modulo 2^16. No saturation.
- COV differences are 16-bit signed. The product is 32-bit signed. Bits [23:8] are added with wrap.
- Division is signed 16-bit by unsigned 8-bit, as floor division toward −∞:
  - Divide the magnitude with a 16-iteration restoring divider.
  - Fixup cycle: if the dividend is negative, negate; if the remainder is also nonzero, subtract 1.
  - Result is the low 16 bits.
- N=0: skip directly from LOADN to WRHI/WRLO writing 0x0000 at addresses 1 and 2, then DONE. No divide-by-zero occurs.

## Timing
- Reset values: `Ack`=0, `MemWrEn`=0, `MemAddr`=0, `MemWrData`=0, state IDLE, accumulator/xbar/ybar=0.
- Latency from the first LOADN cycle to `Ack` high: exactly `4N+54` cycles for N≥1, and 3 cycles for N=0.
- `MemWrEn` is high for exactly two cycles per run:
  - WRHI: addr `2N+1`, high byte.
  - WRLO: addr `2N+2`, low byte.
- `MemWrEn` is 0 in every other state.
- `Ack` rises the cycle after WRLO. The result is in memory by the time `Ack` is visible.
- `Start` high in any non-IDLE state aborts the run: return to IDLE next cycle, `Ack`=0, no further writes. A write completed before the abort stays in memory.
- `Start` held high from reset: the block stays in IDLE indefinitely.
- `Reset` mid-run: immediate return to IDLE and all outputs to their reset values. A following `Start` fall starts a clean run.
- Back-to-back runs: from DONE, raising `Start` clears `Ack`. The next fall relaunches and N is re-read.

## Test plan
- N=3, X={1,2,3}, Y={10,20,27}: xbar 0x0200, ybar 0x1300; `Core[7]`=0x05, `Core[8]`=0xAA; `Ack` exactly 66 cycles after LOADN.
- N=4, X={2,4,8,10}, Y={7,3,5,1}: xbar 0x0600, ybar 0x0400; result 0xFB00 at `Core[9..10]`. Then raise `Start`, reload, and confirm `Ack` drops and the second run is independent.
- Floor rounding: N=3, X={1,1,2}, Y={3,2,1}: dx sum −1/3 path gives xbar 0x0155; result must match the bench's floor model (negative non-exact quotient rounds toward −∞).
- N=0: `Core[1]`=`Core[2]`=0x00 written and `Ack` after 3 cycles; no other writes.
- Assert `Reset` during DIVY (and separately, raise `Start` during COV): `Ack`=0 and `MemWrEn`=0 immediately or next cycle; no result bytes written; a subsequent clean run produces the correct result.
- Wrap: N=255 with all X=Y=255: accumulator wraps without error; result equals the bench model's modulo-2^16 value; `Ack` at 1074 cycles.

Source files
------------

// File: rtl/cov_engine.sv
// Start/Ack covariance responder: reads N, X[], Y[] from data memory, computes the
// 8.8 fixed-point covariance with floor division, writes the 16-bit result back.
module cov_engine #(
  parameter int unsigned NMAX = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic       MemWrEn,
  output logic [7:0] MemWrData
);

  localparam int unsigned CW = $clog2(2 * NMAX + 1);

  typedef enum logic [3:0] {
    IDLE, LOADN, SUMX, DIVX, SUMY, DIVY, COV, DIVC, WRHI, WRLO, DONE
  } state_t;

  state_t        state, state_next;
  logic          start_q, start_qq;
  logic [7:0]    n;
  logic [CW-1:0] cnt;
  logic [15:0]   acc, xbar, ybar, res;
  logic [7:0]    xr;
  logic [15:0]   dq;
  logic [7:0]    dr;

  logic          launch, sum_last, cov_last, div_last;
  logic [CW-1:0] n_ext;

  // divider / covariance datapath signals
  logic          neg, q_bit;
  logic [15:0]   mag, q_src, q_step, q_fix;
  logic [7:0]    r_src, r_step;
  logic [8:0]    trial;
  logic [15:0]   dx, dy, cov_term;
  logic signed [31:0] prod;

  assign launch   = start_qq & ~start_q;
  assign n_ext    = CW'(n);
  assign sum_last = (cnt == n_ext - CW'(1));
  assign cov_last = (cnt == (n_ext << 1) - CW'(1));
  assign div_last = (cnt == CW'(16));
  assign Ack      = (state == DONE);

  always_comb begin
    neg   = acc[15];
    mag   = neg ? (~acc + 16'd1) : acc;
    q_src = (cnt == '0) ? mag : dq;
    r_src = (cnt == '0) ? '0 : dr;
    trial = {r_src, q_src[15]};
    if (trial >= {1'b0, n}) begin
      r_step = 8'(trial - {1'b0, n});
      q_bit  = 1'b1;
    end else begin
      r_step = trial[7:0];
      q_bit  = 1'b0;
    end
    q_step = {q_src[14:0], q_bit};
    // floor toward -inf: -q when exact, -q-1 (== ~q) otherwise
    q_fix  = neg ? ((dr != '0) ? ~dq : (~dq + 16'd1)) : dq;
    dx       = {xr, 8'h00} - xbar;
    dy       = {MemRdData, 8'h00} - ybar;
    prod     = $signed(dx) * $signed(dy);
    cov_term = 16'(prod >>> 8);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = LOADN;
      LOADN:   state_next = (MemRdData == 8'd0) ? WRHI : SUMX;
      SUMX:    if (sum_last) state_next = DIVX;
      DIVX:    if (div_last) state_next = SUMY;
      SUMY:    if (sum_last) state_next = DIVY;
      DIVY:    if (div_last) state_next = COV;
      COV:     if (cov_last) state_next = DIVC;
      DIVC:    if (div_last) state_next = WRHI;
      WRHI:    state_next = WRLO;
      WRLO:    state_next = DONE;
      DONE:    if (launch) state_next = LOADN;
      default: state_next = IDLE;
    endcase
    if (Start && state != IDLE) state_next = IDLE;
  end

  always_comb begin
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    case (state)
      SUMX:    MemAddr = 8'd1 + 8'(cnt);
      SUMY:    MemAddr = n + 8'd1 + 8'(cnt);
      COV:     MemAddr = cnt[0] ? (n + 8'd1 + 8'(cnt >> 1)) : (8'd1 + 8'(cnt >> 1));
      WRHI: begin
        MemAddr   = {n[6:0], 1'b1};
        MemWrEn   = 1'b1;
        MemWrData = res[15:8];
      end
      WRLO: begin
        MemAddr   = {n[6:0], 1'b0} + 8'd2;
        MemWrEn   = 1'b1;
        MemWrData = res[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      n        <= '0;
      cnt      <= '0;
      acc      <= '0;
      xbar     <= '0;
      ybar     <= '0;
      res      <= '0;
      xr       <= '0;
      dq       <= '0;
      dr       <= '0;
    end else begin
      state    <= state_next;
      start_q  <= Start;
      start_qq <= start_q;
      cnt      <= (state_next != state) ? '0 : cnt + CW'(1);
      case (state)
        LOADN: begin
          n   <= MemRdData;
          res <= '0;
        end
        SUMX, SUMY: acc <= acc + {MemRdData, 8'h00};
        DIVX, DIVY, DIVC: begin
          if (!div_last) begin
            dq <= q_step;
            dr <= r_step;
          end else if (state == DIVX) begin
            xbar <= q_fix;
          end else if (state == DIVY) begin
            ybar <= q_fix;
          end else begin
            res <= q_fix;
          end
        end
        COV: begin
          if (!cnt[0]) xr <= MemRdData;
          else         acc <= acc + cov_term;
        end
        default: ;
      endcase
      if (state_next != state &&
          (state_next == SUMX || state_next == SUMY || state_next == COV))
        acc <= '0;
    end
  end

endmodule

// File: tb/tb_cov_engine.sv
// Directed bench for cov_engine: behavioural data memory, host load/launch tasks,
// hand-computed and floor-model expected results, latency, write-count and abort checks.
module tb_cov_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ack;
  logic [7:0] mem_addr, rd_data, wr_data;
  logic       wr_en;

  logic [7:0] mem [256];
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0, host_data = '0;
  int unsigned wr_count = 0;
  int unsigned w0 = 0;

  logic [7:0] xv [256];
  logic [7:0] yv [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cov_engine #(.NMAX(255)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Ack(ack),
    .MemAddr(mem_addr), .MemRdData(rd_data), .MemWrEn(wr_en), .MemWrData(wr_data)
  );

  assign rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (wr_en) begin
      mem[mem_addr] <= wr_data;
      wr_count      <= wr_count + 1;
    end else if (host_we) begin
      mem[host_addr] <= host_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic logic [15:0] cov_model(input int n);
    int sx, sy, xb, yb, acc, dx, dy, p;
    logic [31:0] r;
    if (n == 0) return 16'h0000;
    sx = 0; sy = 0;
    for (int i = 0; i < n; i++) begin
      sx = s16(sx + int'(xv[i]) * 256);
      sy = s16(sy + int'(yv[i]) * 256);
    end
    xb = s16(fdiv(sx, n));
    yb = s16(fdiv(sy, n));
    acc = 0;
    for (int i = 0; i < n; i++) begin
      dx  = s16(int'(xv[i]) * 256 - xb);
      dy  = s16(int'(yv[i]) * 256 - yb);
      p   = dx * dy;
      acc = s16(acc + (p >>> 8));
    end
    r = 32'(fdiv(acc, n));
    return r[15:0];
  endfunction

  task automatic host_wr(input int a, input logic [7:0] d);
    @(negedge clk);
    host_we   = 1'b1;
    host_addr = 8'(a);
    host_data = d;
    @(posedge clk);
    #1 host_we = 1'b0;
  endtask

  // holds Start high while loading, marks the result slots, then drops Start
  task automatic load_run(input int n);
    @(negedge clk);
    start = 1'b1;
    host_wr(0, 8'(n));
    for (int i = 0; i < n; i++) host_wr(1 + i, xv[i]);
    for (int i = 0; i < n; i++) host_wr(n + 1 + i, yv[i]);
    if (n < 127) begin
      host_wr(2 * n + 1, 8'hEE);
      host_wr(2 * n + 2, 8'hEE);
    end
    @(negedge clk);
    w0    = wr_count;
    start = 1'b0;
  endtask

  task automatic wait_ack(input int n, input logic [15:0] exp, input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    int lat_exp;
    lat_exp = (n == 0) ? 3 : 4 * n + 54;
    while (!seen && cyc < 4 * n + 200) begin
      @(posedge clk);
      #1 cyc++;
      if (ack) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      // two edges from the Start fall to the first LOADN cycle
      check({tag, "_latency"}, 32'(cyc - 2), 32'(lat_exp));
      check({tag, "_res_hi"}, 32'(mem[8'(2 * n + 1)]), 32'(exp[15:8]));
      check({tag, "_res_lo"}, 32'(mem[8'(2 * n + 2)]), 32'(exp[7:0]));
      check({tag, "_writes"}, wr_count - w0, 32'd2);
      check({tag, "_wren_done"}, 32'(wr_en), 32'd0);
      @(posedge clk);
      #1 check({tag, "_ack_hold"}, 32'(ack), 32'd1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 check({tag, "_ack_clear"}, 32'(ack), 32'd0);
    end
  endtask

  task automatic set_vec(input int idx, input logic [7:0] x, input logic [7:0] y);
    xv[idx] = x;
    yv[idx] = y;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    #12;
    check("rst_ack",   32'(ack),      32'd0);
    check("rst_wren",  32'(wr_en),    32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(wr_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("hold_idle_ack", 32'(ack), 32'd0);
    check("hold_idle_writes", wr_count, 32'd0);

    set_vec(0, 8'd1, 8'd10); set_vec(1, 8'd2, 8'd20); set_vec(2, 8'd3, 8'd27);
    load_run(3);
    wait_ack(3, 16'h05AA, "t1");

    set_vec(0, 8'd2, 8'd7); set_vec(1, 8'd4, 8'd3); set_vec(2, 8'd8, 8'd5); set_vec(3, 8'd10, 8'd1);
    load_run(4);
    wait_ack(4, 16'hFB00, "t2");

    set_vec(0, 8'd1, 8'd3); set_vec(1, 8'd1, 8'd2); set_vec(2, 8'd2, 8'd1);
    load_run(3);
    wait_ack(3, cov_model(3), "floor");

    load_run(0);
    wait_ack(0, 16'h0000, "n0");

    // reset while dividing for ybar
    set_vec(0, 8'd1, 8'd10); set_vec(1, 8'd2, 8'd20); set_vec(2, 8'd3, 8'd27);
    load_run(3);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_wren", 32'(wr_en), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1 check("rst_mid_nowrite", wr_count - w0, 32'd0);
    check("rst_mid_mem7", 32'(mem[7]), 32'hEE);
    check("rst_mid_mem8", 32'(mem[8]), 32'hEE);
    load_run(3);
    wait_ack(3, 16'h05AA, "rst_rerun");

    // Start raised during the covariance pass
    set_vec(0, 8'd2, 8'd7); set_vec(1, 8'd4, 8'd3); set_vec(2, 8'd8, 8'd5); set_vec(3, 8'd10, 8'd1);
    load_run(4);
    repeat (47) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 check("abort_ack", 32'(ack), 32'd0);
    check("abort_wren", 32'(wr_en), 32'd0);
    repeat (80) @(posedge clk);
    #1 check("abort_nowrite", wr_count - w0, 32'd0);
    check("abort_mem9", 32'(mem[9]), 32'hEE);
    check("abort_mem10", 32'(mem[10]), 32'hEE);
    load_run(4);
    wait_ack(4, 16'hFB00, "abort_rerun");

    for (int i = 0; i < 255; i++) set_vec(i, 8'd255, 8'd255);
    load_run(255);
    wait_ack(255, cov_model(255), "wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
